// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory/writeback stage: writeback selects, load/store funct3 codes, MEM/WB layout.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mem_stage_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Load/store funct3 codes, matching inst_defs.sv
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] pc_4;
    logic [4:0]  rd;
    logic        reg_wr_en;
    logic [1:0]  reg_wr_ctrl;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic        mmio_hit;
    logic        misalign;
  } memwb_t;

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-writable single-port data RAM, read-first, written to map onto block RAM.
// Latency: read data valid one cycle after the address edge.
// Backpressure: none; one access per cycle.
module data_mem #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_stage.sv
// Memory/writeback stage: data RAM loads/stores, MMIO output register, MEM/WB register and writeback mux.
// Latency: writeback result valid the cycle after EX/MEM presents the instruction.
// Backpressure: none; accepts one instruction (or bubble) every cycle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_out_EXMEM,
  input  logic [2:0]  funct3_EXMEM,
  input  logic        mem_wr_en_EXMEM,
  input  logic [31:0] rs2_data_EXMEM,
  input  logic        reg_wr_en_EXMEM,
  input  logic [1:0]  reg_wr_ctrl_EXMEM,
  input  logic [4:0]  rd_EXMEM,
  input  logic [31:0] pc_4_EXMEM,
  output logic        reg_wr_en_WBID,
  output logic [4:0]  rd_WBID,
  output logic [31:0] reg_wr_data_WBID,
  output logic [31:0] mmio_data,
  output logic        mmio_valid,
  output logic        misalign_err
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic        is_load;
  logic        mmio_hit;
  logic        misalign;
  logic        mmio_wr;
  logic [3:0]  byte_en;
  logic [31:0] st_dat;
  logic [31:0] ram_rdata;
  memwb_t      memwb;

  always_comb begin
    is_load  = reg_wr_ctrl_EXMEM == WB_MEM;
    mmio_hit = ALU_out_EXMEM == MMIO_BASE;
    misalign = (is_load || mem_wr_en_EXMEM) && is_misaligned(funct3_EXMEM, ALU_out_EXMEM[1:0]);
    mmio_wr  = mem_wr_en_EXMEM && mmio_hit;
    byte_en  = 4'b0000;
    st_dat   = rs2_data_EXMEM;
    case (funct3_EXMEM)
      F3_SB: begin
        byte_en = 4'b0001 << ALU_out_EXMEM[1:0];
        st_dat  = {4{rs2_data_EXMEM[7:0]}};
      end
      F3_SH: begin
        byte_en = ALU_out_EXMEM[1] ? 4'b1100 : 4'b0011;
        st_dat  = {2{rs2_data_EXMEM[15:0]}};
      end
      F3_SW:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
    // MMIO hits, misaligned stores and stores racing reset never reach the RAM
    if (!mem_wr_en_EXMEM || mmio_hit || misalign || reset) byte_en = 4'b0000;
  end

  data_mem #(.WORDS(DMEM_WORDS)) u_dmem (
    .clk   (clk),
    .addr  (ALU_out_EXMEM[AW+1:2]),
    .we    (byte_en),
    .wdata (st_dat),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      memwb        <= '0;
      mmio_data    <= 32'h0;
      mmio_valid   <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      memwb <= '{alu_out:     ALU_out_EXMEM,
                 pc_4:        pc_4_EXMEM,
                 rd:          rd_EXMEM,
                 reg_wr_en:   reg_wr_en_EXMEM,
                 reg_wr_ctrl: reg_wr_ctrl_EXMEM,
                 funct3:      funct3_EXMEM,
                 addr_lo:     ALU_out_EXMEM[1:0],
                 mmio_hit:    mmio_hit,
                 misalign:    misalign};
      mmio_valid <= mmio_wr;
      if (mmio_wr) mmio_data <= rs2_data_EXMEM;
      if (misalign) misalign_err <= 1'b1;
    end
  end

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;

  // mmio_data cannot change between the load edge and WB, so it is read live here
  always_comb begin
    lane_b = ram_rdata[8*memwb.addr_lo +: 8];
    lane_h = memwb.addr_lo[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (memwb.funct3)
      F3_LB:   load_val = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  load_val = {24'h0, lane_b};
      F3_LH:   load_val = {{16{lane_h[15]}}, lane_h};
      F3_LHU:  load_val = {16'h0, lane_h};
      F3_LW:   load_val = ram_rdata;
      default: load_val = ram_rdata;
    endcase
    if (memwb.misalign)      load_val = 32'h0;
    else if (memwb.mmio_hit) load_val = mmio_data;

    case (memwb.reg_wr_ctrl)
      WB_MEM:  reg_wr_data_WBID = load_val;
      WB_PC4:  reg_wr_data_WBID = memwb.pc_4;
      default: reg_wr_data_WBID = memwb.alu_out;
    endcase
  end

  assign reg_wr_en_WBID = memwb.reg_wr_en;
  assign rd_WBID        = memwb.rd;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-level memory model, directed pins, then randomized traffic.
module tb_mem_stage;

  localparam int          WORDS = 1024;
  localparam int          NBYTE = WORDS * 4;
  localparam logic [31:0] MBASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_out;
  logic [2:0]  funct3;
  logic        mem_wr_en;
  logic [31:0] rs2_data;
  logic        reg_wr_en;
  logic [1:0]  reg_wr_ctrl;
  logic [4:0]  rd;
  logic [31:0] pc_4;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] mmio_data;
  logic        mmio_valid;
  logic        misalign_err;

  always #5 clk = ~clk;

  mem_stage #(.DMEM_WORDS(WORDS), .MMIO_BASE(MBASE)) dut (
    .clk               (clk),
    .reset             (reset),
    .ALU_out_EXMEM     (alu_out),
    .funct3_EXMEM      (funct3),
    .mem_wr_en_EXMEM   (mem_wr_en),
    .rs2_data_EXMEM    (rs2_data),
    .reg_wr_en_EXMEM   (reg_wr_en),
    .reg_wr_ctrl_EXMEM (reg_wr_ctrl),
    .rd_EXMEM          (rd),
    .pc_4_EXMEM        (pc_4),
    .reg_wr_en_WBID    (wb_en),
    .rd_WBID           (wb_rd),
    .reg_wr_data_WBID  (wb_data),
    .mmio_data         (mmio_data),
    .mmio_valid        (mmio_valid),
    .misalign_err      (misalign_err)
  );

  typedef struct {
    logic [31:0] a;
    logic [2:0]  f3;
    logic        we;
    logic [31:0] rs2;
    logic        rwe;
    logic [1:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic        rst;
  } ins_t;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: memory as a flat little-endian byte array
  logic [7:0]  mb [NBYTE];
  logic [31:0] m_mmio = 32'h0;
  logic        m_err  = 1'b0;

  logic        exp_on = 1'b0;
  logic        exp_en, exp_mv, exp_me;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data, exp_md;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endfunction

  function automatic ins_t mk(input logic [31:0] a, input logic [2:0] f3, input logic we,
                              input logic [31:0] rs2, input logic rwe, input logic [1:0] ctrl,
                              input logic [4:0] rdi, input logic [31:0] pc4, input logic rst);
    ins_t t;
    t.a = a; t.f3 = f3; t.we = we; t.rs2 = rs2; t.rwe = rwe;
    t.ctrl = ctrl; t.rd = rdi; t.pc4 = pc4; t.rst = rst;
    return t;
  endfunction

  // Drive one EX/MEM word, predict the WB outputs after the edge, publish them to the checker
  task automatic issue(input ins_t t);
    int          size, idx;
    logic        mis, hit, mv;
    logic [31:0] v, d;
    reset = t.rst; alu_out = t.a; funct3 = t.f3; mem_wr_en = t.we; rs2_data = t.rs2;
    reg_wr_en = t.rwe; reg_wr_ctrl = t.ctrl; rd = t.rd; pc_4 = t.pc4;
    mv = 1'b0;
    d  = 32'h0;
    if (t.rst) begin
      m_mmio = 32'h0;
      m_err  = 1'b0;
    end else begin
      size = (t.f3[1:0] == 2'd0) ? 1 : (t.f3[1:0] == 2'd1) ? 2 : (t.f3[1:0] == 2'd2) ? 4 : 0;
      mis  = (t.we || t.ctrl == 2'b01) && size > 1 && (t.a % size) != 0;
      hit  = t.a == MBASE;
      idx  = int'(t.a % NBYTE);
      if (t.ctrl == 2'b10) d = t.pc4;
      else if (t.ctrl == 2'b01) begin
        if (mis) d = 32'h0;
        else if (hit) d = m_mmio;
        else begin
          v = 32'h0;
          for (int b = 0; b < size; b++) v = v | (32'(mb[idx + b]) << (8 * b));
          if (!t.f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
          d = v;
        end
      end else d = t.a;
      if (t.we) begin
        if (hit) begin
          m_mmio = t.rs2;
          mv     = 1'b1;
        end else if (!mis && size > 0) begin
          for (int b = 0; b < size; b++) mb[idx + b] = t.rs2[8*b +: 8];
        end
      end
      if (mis) m_err = 1'b1;
    end
    @(posedge clk);
    #1;
    exp_en   = t.rst ? 1'b0 : t.rwe;
    exp_rd   = t.rst ? 5'd0 : t.rd;
    exp_data = d;
    exp_md   = m_mmio;
    exp_mv   = mv;
    exp_me   = m_err;
    exp_on   = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      chk("wb_en",        32'(wb_en),        32'(exp_en));
      chk("wb_rd",        32'(wb_rd),        32'(exp_rd));
      chk("wb_data",      wb_data,           exp_data);
      chk("mmio_data",    mmio_data,         exp_md);
      chk("mmio_valid",   32'(mmio_valid),   32'(exp_mv));
      chk("misalign_err", 32'(misalign_err), 32'(exp_me));
    end
  end

  ins_t        t;
  logic [31:0] a;
  int          k;
  logic [2:0]  lf3 [5];

  initial begin
    lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010; lf3[3] = 3'b100; lf3[4] = 3'b101;

    issue(mk(32'h0, 3'd0, 1'b0, 32'h0, 1'b1, 2'b10, 5'd9, 32'h44, 1'b1));
    #2;
    chk("rst_en", 32'(wb_en), 32'h0);
    chk("rst_data", wb_data, 32'h0);

    // Give every RAM word a known value so later loads are fully predictable
    for (int i = 0; i < WORDS; i++)
      issue(mk(32'(i) * 4, 3'b010, 1'b1, 32'h1000_0000 + 32'(i), 1'b0, 2'b00, 5'd0, 32'h0, 1'b0));

    issue(mk(32'h10, 3'b010, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00, 5'd0, 32'h0, 1'b0));
    issue(mk(32'h10, 3'b010, 1'b0, 32'h0, 1'b1, 2'b01, 5'd1, 32'h0, 1'b0));
    #2 chk("lw_deadbeef", wb_data, 32'hDEAD_BEEF);
    issue(mk(32'h13, 3'b000, 1'b1, 32'h0000_0080, 1'b0, 2'b00, 5'd0, 32'h0, 1'b0));
    issue(mk(32'h13, 3'b000, 1'b0, 32'h0, 1'b1, 2'b01, 5'd2, 32'h0, 1'b0));
    #2 chk("lb_sext", wb_data, 32'hFFFF_FF80);
    issue(mk(32'h13, 3'b100, 1'b0, 32'h0, 1'b1, 2'b01, 5'd2, 32'h0, 1'b0));
    #2 chk("lbu_zext", wb_data, 32'h0000_0080);
    issue(mk(32'h10, 3'b010, 1'b0, 32'h0, 1'b1, 2'b01, 5'd2, 32'h0, 1'b0));
    #2 chk("lw_after_sb", wb_data, 32'h80AD_BEEF);
    issue(mk(32'h12, 3'b001, 1'b1, 32'h0000_1234, 1'b0, 2'b00, 5'd0, 32'h0, 1'b0));
    issue(mk(32'h12, 3'b101, 1'b0, 32'h0, 1'b1, 2'b01, 5'd3, 32'h0, 1'b0));
    #2 chk("lhu", wb_data, 32'h0000_1234);
    issue(mk(32'h11, 3'b001, 1'b0, 32'h0, 1'b1, 2'b01, 5'd3, 32'h0, 1'b0));
    #2 chk("lh_misaligned_data", wb_data, 32'h0);
    chk("lh_misaligned_err", 32'(misalign_err), 32'h1);
    issue(mk(32'h10, 3'b010, 1'b0, 32'h0, 1'b1, 2'b01, 5'd3, 32'h0, 1'b0));
    #2 chk("lw_ram_unchanged", wb_data, 32'h1234_BEEF);
    issue(mk(MBASE, 3'b010, 1'b1, 32'hCAFE_0001, 1'b0, 2'b00, 5'd0, 32'h0, 1'b0));
    #2 chk("mmio_data", mmio_data, 32'hCAFE_0001);
    chk("mmio_valid_hi", 32'(mmio_valid), 32'h1);
    issue(mk(MBASE, 3'b010, 1'b0, 32'h0, 1'b1, 2'b01, 5'd4, 32'h0, 1'b0));
    #2 chk("mmio_valid_lo", 32'(mmio_valid), 32'h0);
    chk("lw_mmio", wb_data, 32'hCAFE_0001);
    issue(mk(32'h7, 3'b000, 1'b0, 32'h0, 1'b1, 2'b00, 5'd5, 32'h0, 1'b0));
    #2 chk("alu_en", 32'(wb_en), 32'h1);
    chk("alu_rd", 32'(wb_rd), 32'h5);
    chk("alu_data", wb_data, 32'h7);
    issue(mk(32'h9999, 3'b000, 1'b0, 32'h0, 1'b1, 2'b10, 5'd1, 32'h0000_0104, 1'b0));
    #2 chk("jal_pc4", wb_data, 32'h0000_0104);
    issue(mk(32'h20, 3'b010, 1'b1, 32'h55AA_55AA, 1'b1, 2'b00, 5'd6, 32'h0, 1'b1));
    #2 chk("rst_mid_en", 32'(wb_en), 32'h0);
    chk("rst_mid_rd", 32'(wb_rd), 32'h0);
    chk("rst_mid_mmio", mmio_data, 32'h0);
    chk("rst_mid_err", 32'(misalign_err), 32'h0);
    issue(mk(32'h20, 3'b010, 1'b0, 32'h0, 1'b1, 2'b01, 5'd6, 32'h0, 1'b0));
    #2 chk("store_discarded", wb_data, 32'h1000_0008);

    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, 99);
      a = ($urandom_range(0, 1) == 1 ? ($urandom & 32'hFFFF_F000) : 32'h0) | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 19) == 0) a = MBASE;
      t = mk(a, 3'd0, 1'b0, $urandom, 1'($urandom), 2'b00, 5'($urandom), $urandom, 1'b0);
      if (k < 4) begin
        t.rst = 1'b1;
        t.we  = 1'($urandom);
        t.f3  = 3'b010;
      end else if (k < 10) begin
        t = mk(32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
      end else if (k < 35) begin
        t.ctrl = $urandom_range(0, 1) == 1 ? 2'b11 : 2'b00;
        t.f3   = 3'($urandom);
      end else if (k < 45) begin
        t.ctrl = 2'b10;
      end else if (k < 70) begin
        t.we = 1'b1;
        t.f3 = ($urandom_range(0, 9) == 0) ? 3'b011 : 3'($urandom_range(0, 2));
      end else begin
        t.ctrl = 2'b01;
        t.f3   = lf3[$urandom_range(0, 4)];
      end
      issue(t);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory/writeback stage of the pipelined RV32IM core. Consumes the EX/MEM pipeline register and performs data-memory loads and stores through an internal byte-enable synchronous RAM, plus one memory-mapped output register. It holds the MEM/WB pipeline register and drives the writeback result (`reg_wr_en_WBID`, `rd_WBID`, `reg_wr_data_WBID`) to the register file and to the EX forwarding logic.

## Interface
- `DMEM_WORDS`, 1024: data RAM depth in 32-bit words; power of two.
- `MMIO_BASE`, 32'h8000_0000: address of the memory-mapped output register.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ALU_out_EXMEM` in 32: load/store byte address, or ALU result.
- `funct3_EXMEM` in 3: access size and sign, from the `inst_defs.sv` load/store codes.
- `mem_wr_en_EXMEM` in 1: store request.
- `rs2_data_EXMEM` in 32: store data, already forwarded.
- `reg_wr_en_EXMEM` in 1: instruction writes rd.
- `reg_wr_ctrl_EXMEM` in 2: writeback select. 00 = ALU, 01 = load, 10 = pc+4, 11 = ALU.
- `rd_EXMEM` in 5: destination register.
- `pc_4_EXMEM` in 32: link value.
- `reg_wr_en_WBID` out 1: register file write enable.
- `rd_WBID` out 5: writeback destination.
- `reg_wr_data_WBID` out 32: writeback data.
- `mmio_data` out 32: MMIO register contents.
- `mmio_valid` out 1: one-cycle pulse after each MMIO store.
- `misalign_err` out 1: sticky misaligned-access flag.

## Operation
- Load vs. ALU instruction: a load is any instruction with `reg_wr_ctrl_EXMEM==01`. Every other instruction passes through to the MEM/WB register unchanged.
- RAM address: word index is `ALU_out_EXMEM[log2(DMEM_WORDS)+1:2]`. Upper address bits are ignored, so out-of-range addresses alias into the RAM. The only exception is an address equal to `MMIO_BASE`, which maps to the MMIO register.
- Stores:
  - SB (000): byte enable `1<<addr[1:0]`, data byte replicated across all four lanes.
  - SH (001): enables 0011 or 1100 selected by `addr[1]`, data halfword replicated.
  - SW (010): enables 1111.
  - Any other funct3 with `mem_wr_en` set: no write.
- MMIO store (any size) to `MMIO_BASE`:
  - `mmio_data` takes the full `rs2_data_EXMEM`.
  - `mmio_valid` is 1 for exactly the next cycle.
  - The RAM is not written.
- Loads:
  - The RAM reads on the same edge; MEM/WB captures funct3 and `addr[1:0]`.
  - In the WB cycle the RAM output word is lane-selected and extended: LB/LH sign-extend, LBU/LHU zero-extend, LW is the full word.
  - A load from `MMIO_BASE` returns `mmio_data` as sampled on that edge.
- Misalignment:
  - Halfword access with `addr[0]==1`, or word access with `addr[1:0]!=0`, is misaligned.
  - A misaligned store is suppressed.
  - A misaligned load writes back 0.
  - `misalign_err` is set and stays set until reset.
- Writeback mux (combinational from MEM/WB and RAM output): selects ALU, load, or pc+4 per the registered `reg_wr_ctrl`.
- Bubbles: EX inserts zeros on `div_stall`; an all-zero EX/MEM word is a NOP. This block has no stall input.

## Timing
- An instruction present on the EX/MEM outputs in cycle N has `reg_wr_*_WBID` valid during cycle N+1 and written to the register file at the end of N+1.
- Store at N followed by a load of the same word at N+1: the load returns the new data, because the write completes at the N edge.
- Load-use distance 1 cannot be forwarded from this stage's EX/MEM slot. The hazard unit stalls; this block does nothing about it.
- Reset, applied on the edge:
  - All MEM/WB fields are cleared, giving `reg_wr_en_WBID=0`, `rd_WBID=0`, `reg_wr_data_WBID=0`.
  - `mmio_data=0`, `mmio_valid=0`, `misalign_err=0`.
  - RAM contents are not cleared.
  - An in-flight store presented with reset high is discarded.
- A store with `reg_wr_en_EXMEM=1` is treated as a store; the writeback enable passes through unchanged and is not masked.

## Structure
- Shared package additions:
  - `WB_ALU`, `WB_MEM`, `WB_PC4` writeback-select constants.
  - Load/store funct3 names, placed alongside the existing `inst_defs.sv` codes.
- Sub-module `data_mem`: `DMEM_WORDS` × 32 RAM with synchronous read, byte-write enables and read-first behaviour; must infer BRAM.
- `mem_stage` contains:
  - store lane logic;
  - the MMIO register;
  - the MEM/WB register (ALU out, pc+4, rd, reg_wr_en, reg_wr_ctrl, funct3, addr[1:0], mmio-hit);
  - load extension and the writeback mux.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 → `reg_wr_data_WBID=0xDEADBEEF` one cycle after the load is presented.
- SB 0x80 to 0x13, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LW 0x10 → 0x80ADBEEF.
- SH 0x1234 to 0x12, then LHU 0x12 → 0x00001234; LH 0x11 → 0, `misalign_err=1`, RAM unchanged.
- SW 0xCAFE0001 to `MMIO_BASE` → `mmio_data=0xCAFE0001`, `mmio_valid` high for exactly one cycle; a following LW `MMIO_BASE` returns it.
- ALU op with rd=5, result 7 → `reg_wr_en_WBID=1`, `rd_WBID=5`, data 7; JAL with ctrl 10 → data = `pc_4`.
- Reset asserted mid-stream with a store pending → all outputs 0 next cycle; the store is not visible on a later load.
